// File: rtl/down_counter_if.sv
// Load/start control and status bundle for the loadable down counter.
// The bench drives the master side; the counter implements the slave side.
interface down_counter_if #(
  parameter int WIDTH = 12
);
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             start;
  logic             pause;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output load_valid, load_value, start, pause, stop, auto_reload,
    input  load_ready, count, busy, done, tc
  );

  modport slave (
    input  load_valid, load_value, start, pause, stop, auto_reload,
    output load_ready, count, busy, done, tc
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter / interval timer with optional auto-reload.
// It emits a one-cycle registered terminal-count pulse when the count reaches zero.
module down_counter #(
  parameter int WIDTH = 12
) (
  input  logic          clk,
  input  logic          reset,
  down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] count_q, count_nx;
  logic [WIDTH-1:0] reload_q, reload_nx;
  logic             tc_q, tc_nx;
  logic             load_ok;

  // Decrement that stops at zero, so the count can never wrap.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    if (v == '0) return '0;
    else         return v - WIDTH'(1);
  endfunction

  assign load_ok = (state_q != RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      count_q  <= count_nx;
      reload_q <= reload_nx;
      tc_q     <= tc_nx;
    end
  end

  always_comb begin
    state_nx  = state_q;
    count_nx  = count_q;
    reload_nx = reload_q;
    tc_nx     = 1'b0;
    if (bus.load_valid && load_ok) begin
      // A load wins over a simultaneous start and never changes state.
      count_nx  = bus.load_value;
      reload_nx = bus.load_value;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            if (count_q != '0) begin
              state_nx = RUN;
            end else begin
              tc_nx    = 1'b1;
              state_nx = DONE;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_nx = IDLE;
          end else if (bus.pause) begin
            count_nx = count_q;
          end else if (count_q != '0) begin
            count_nx = sat_dec(count_q);
            tc_nx    = (count_q == WIDTH'(1));
          end else if (bus.auto_reload && (reload_q != '0)) begin
            count_nx = reload_q;
          end else begin
            state_nx = DONE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.load_ready = load_ok;

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: hand-computed count/tc/status sequences
// covering load, start, pause, stop, auto-reload and asynchronous reset.
module tb_down_counter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  down_counter_if #(.WIDTH(12)) bus ();

  down_counter #(.WIDTH(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic [11:0] c, input logic b,
                              input logic d, input logic t);
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".busy"},  32'(bus.busy),  32'(b));
    check({tag, ".done"},  32'(bus.done),  32'(d));
    check({tag, ".tc"},    32'(bus.tc),    32'(t));
  endtask

  initial begin
    logic [11:0] ar_cnt [6];
    logic        ar_tc  [6];
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_value  = '0;
    bus.start       = 1'b0;
    bus.pause       = 1'b0;
    bus.stop        = 1'b0;
    bus.auto_reload = 1'b0;

    #2;
    check_status("reset", 12'h000, 1'b0, 1'b0, 1'b0);
    check("reset.load_ready", 32'(bus.load_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // Reset mid-run
    bus.load_valid = 1'b1; bus.load_value = 12'd5;
    tick();
    check("rm.load", 32'(bus.count), 32'd5);
    bus.load_valid = 1'b0; bus.start = 1'b1;
    tick();
    check_status("rm.start", 12'd5, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick();
    tick();
    check("rm.cnt3", 32'(bus.count), 32'd3);
    reset = 1'b0;
    #2;
    check_status("rm.async", 12'd0, 1'b0, 1'b0, 1'b0);
    check("rm.async.load_ready", 32'(bus.load_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_status("rm.after", 12'd0, 1'b0, 1'b0, 1'b0);

    // One-shot
    bus.load_valid = 1'b1; bus.load_value = 12'd3;
    tick();
    check("os.load", 32'(bus.count), 32'd3);
    bus.load_valid = 1'b0; bus.start = 1'b1;
    tick();
    check_status("os.s3", 12'd3, 1'b1, 1'b0, 1'b0);
    check("os.load_ready_run", 32'(bus.load_ready), 32'd0);
    bus.start = 1'b0;
    tick(); check_status("os.c2", 12'd2, 1'b1, 1'b0, 1'b0);
    tick(); check_status("os.c1", 12'd1, 1'b1, 1'b0, 1'b0);
    tick(); check_status("os.c0", 12'd0, 1'b1, 1'b0, 1'b1);
    tick(); check_status("os.done", 12'd0, 1'b0, 1'b1, 1'b0);
    check("os.load_ready", 32'(bus.load_ready), 32'd1);

    // Auto-reload, period 3
    bus.load_valid = 1'b1; bus.load_value = 12'd2;
    tick();
    check_status("ar.load", 12'd2, 1'b0, 1'b1, 1'b0);
    bus.load_valid = 1'b0; bus.auto_reload = 1'b1; bus.start = 1'b1;
    tick();
    check_status("ar.start", 12'd2, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    ar_cnt = '{12'd1, 12'd0, 12'd2, 12'd1, 12'd0, 12'd2};
    ar_tc  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      tick();
      check_status($sformatf("ar.step%0d", i), ar_cnt[i], 1'b1, 1'b0, ar_tc[i]);
    end
    bus.stop = 1'b1;
    tick();
    check_status("ar.stop", 12'd2, 1'b0, 1'b0, 1'b0);
    bus.stop = 1'b0; bus.auto_reload = 1'b0;

    // Pause
    bus.load_valid = 1'b1; bus.load_value = 12'd10;
    tick();
    bus.load_valid = 1'b0; bus.start = 1'b1;
    tick();
    check_status("pa.start", 12'd10, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick(); tick(); tick();
    check("pa.c7", 32'(bus.count), 32'd7);
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_status($sformatf("pa.hold%0d", i), 12'd7, 1'b1, 1'b0, 1'b0);
    end
    bus.pause = 1'b0;
    tick();
    check_status("pa.resume", 12'd6, 1'b1, 1'b0, 1'b0);
    bus.stop = 1'b1;
    tick();
    check_status("pa.stop", 12'd6, 1'b0, 1'b0, 1'b0);
    bus.stop = 1'b0;

    // Paused zero cycle
    bus.load_valid = 1'b1; bus.load_value = 12'd1;
    tick();
    bus.load_valid = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_status("pz.zero", 12'd0, 1'b1, 1'b0, 1'b1);
    bus.pause = 1'b1;
    tick();
    check_status("pz.paused", 12'd0, 1'b1, 1'b0, 1'b0);
    bus.pause = 1'b0;
    tick();
    check_status("pz.done", 12'd0, 1'b0, 1'b1, 1'b0);

    // Zero load
    bus.load_valid = 1'b1; bus.load_value = 12'd0;
    tick();
    bus.load_valid = 1'b0; bus.start = 1'b1;
    tick();
    check_status("zl.start", 12'd0, 1'b0, 1'b1, 1'b1);
    bus.start = 1'b0;
    tick();
    check_status("zl.after", 12'd0, 1'b0, 1'b1, 1'b0);

    // Load blocked during RUN, then stop and resume
    bus.load_valid = 1'b1; bus.load_value = 12'hFFF;
    tick();
    check("lb.load", 32'(bus.count), 32'hFFF);
    bus.load_valid = 1'b0; bus.start = 1'b1;
    tick();
    check_status("lb.start", 12'hFFF, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    bus.load_valid = 1'b1; bus.load_value = 12'h005;
    check("lb.load_ready", 32'(bus.load_ready), 32'd0);
    tick();
    check("lb.ignored", 32'(bus.count), 32'hFFE);
    tick(); tick(); tick(); tick();
    check("lb.cFFA", 32'(bus.count), 32'hFFA);
    bus.load_valid = 1'b0; bus.stop = 1'b1;
    tick();
    check_status("lb.stop", 12'hFFA, 1'b0, 1'b0, 1'b0);
    tick();
    check_status("lb.stop_idle", 12'hFFA, 1'b0, 1'b0, 1'b0);
    bus.stop = 1'b0; bus.start = 1'b1;
    tick();
    check_status("lb.restart", 12'hFFA, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick();
    check("lb.cFF9", 32'(bus.count), 32'hFF9);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.load_valid = 1'b1; bus.load_value = 12'h005; bus.start = 1'b1;
    tick();
    check_status("lb.load_start", 12'h005, 1'b0, 1'b0, 1'b0);
    bus.load_valid = 1'b0; bus.start = 1'b0;
    tick();
    check_status("lb.idle_hold", 12'h005, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/down_counter.md
# down_counter

Loadable 12-bit down counter and interval timer. It is the counterpart to the free-running up counter: software-style load/start control, a count that decrements to zero, and an optional auto-reload for periodic tick generation. It sits beside the up counter in the counter/timer group and drives a one-cycle terminal-count pulse (`tc`) to downstream logic.

## Interface
- `WIDTH`, default 12: counter and load width in bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `load_valid` in 1: a load value is offered.
- `load_value` in WIDTH: value to load.
- `load_ready` out 1: load can be accepted; high in IDLE and DONE only.
- `start` in 1: begin counting from the current count.
- `pause` in 1: hold the count while in RUN.
- `stop` in 1: abort RUN and return to IDLE with the count held.
- `auto_reload` in 1: reload on reaching zero instead of finishing.
- `count` out WIDTH: current count, registered.
- `busy` out 1: state is RUN.
- `done` out 1: state is DONE.
- `tc` out 1: registered pulse, high exactly in the cycle where `count`==0 is reached.

## Operation
- **Reset (asynchronous, `reset`=0).** Outputs take their reset values immediately and hold them while low.
  - State is IDLE; `count`=0; reload register=0.
  - `tc`=0, `busy`=0, `done`=0, `load_ready`=1.
- **Load.** On `load_valid`&&`load_ready` at an edge, both `count` and the reload register take `load_value`.
  - Load has priority over `start` in the same cycle; that `start` is ignored.
  - The state does not change on a load. A load in DONE leaves DONE.
- **IDLE / DONE + `start`** (no load in the same cycle):
  - `count`>0: go to RUN.
  - `count`==0: set `tc`=1 and go to DONE.
- **RUN**, priority `stop` > `pause` > count:
  - `stop`: go to IDLE; `count` is held.
  - `pause`: `count` holds; `tc`=0.
  - `count`>1: decrement.
  - `count`==1: set `count` to 0 and `tc` to 1.
  - `count`==0 with `auto_reload`=1 and reload≠0: set `count` to the reload value and stay in RUN.
  - `count`==0 otherwise: go to DONE; `count` stays 0.
- **DONE.** `count`=0 and `done`=1. Leave DONE by `start` (after a load) or by reset. `stop` is ignored outside RUN.
- **Outputs.** `busy` and `done` decode the state. `load_ready` = state≠RUN.
- **Range.** The count never underflows: it stops at 0. `load_value`=12'hFFF gives the maximum period.
- **Auto-reload period.** With reload value N≥1 and no pause, the period is N+1 cycles, with one `tc` per period. `auto_reload` is sampled in the zero cycle.

## Timing
- **Load.** Accepted at edge k; `count`=`load_value` after edge k.
- **Start.** At edge k with `count`=N: `busy`=1 after edge k, with `count` still N.
  - The first decrement happens at edge k+1.
  - `count`=0 and `tc`=1 after edge k+N.
  - With `auto_reload`=0: DONE after edge k+N+1.
- **`tc`.** Width is exactly one cycle unless the zero cycle is paused. A paused zero cycle holds `count`=0 with `tc`=0.
- **`pause`.** Takes effect at the same edge: no decrement at any edge where `pause`=1.
- **Reset mid-RUN.** Outputs go to their reset values asynchronously. After `reset` deasserts, no counting occurs until a new `start`.

## Test plan
- **Reset mid-run.** Load 5, start, drop `reset` after 2 cycles -> `count`=0, `busy`=0 and `tc`=0 without waiting for a clock edge. After release, `count` holds at 0.
- **One-shot.** Load 3, start (`auto_reload`=0) -> `count` runs 3,3,2,1,0. `tc`=1 only in the 0 cycle. Next cycle `done`=1 and `load_ready`=1.
- **Auto-reload.** Load 2, `auto_reload`=1, start -> `count` runs 2,1,0,2,1,0,2. `tc` pulses every 3 cycles and `busy` stays 1.
- **Pause.** Load 10, start, assert `pause` for 4 cycles at `count`=7 -> `count` holds 7 and `tc`=0. Counting resumes at 6 on the first unpaused edge.
- **Zero load.** Load 0, start -> `tc`=1 one cycle after `start` and `done`=1 the same cycle; `busy` never asserts.
- **Load blocked, then stop.** Load 12'hFFF, start, assert `load_valid` with 12'h005 during RUN -> `load_ready`=0 and the load is ignored. `stop` at `count`=12'hFFA -> IDLE with `count` held at 12'hFFA. A new `start` resumes at 12'hFFA, and `load_valid`+`start` in the same cycle performs only the load.
